// File: rtl/tug_pkg.sv
// Shared types for the tug-of-war playfield: winner encoding and round FSM states.
package tug_pkg;

    typedef enum logic [1:0] {
        WIN_NONE  = 2'b00,
        WIN_LEFT  = 2'b01,
        WIN_RIGHT = 2'b10
    } winner_t;

    typedef enum logic {
        S_PLAY,
        S_WON
    } play_state_t;

endpackage

// File: rtl/tug_playfield_sat_counter.sv
// Saturating up-counter: counts inc pulses, sticks at MAX.
module sat_counter #(
    parameter int unsigned MAX = 7
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         inc,
    output logic [$clog2(MAX+1)-1:0]     count
);

    localparam int unsigned W = $clog2(MAX + 1);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (inc && (count != W'(MAX))) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/tug_playfield.sv
// Tug-of-war playfield: moves one lit LED on press pulses, detects wins,
// keeps per-player tallies and restarts the round after a hold period.
module tug_playfield
    import tug_pkg::*;
#(
    parameter int unsigned NUM_LIGHTS  = 9,
    parameter int unsigned WIN_MAX     = 7,
    parameter int unsigned HOLD_CYCLES = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             l_press,
    input  logic                             r_press,
    output logic [NUM_LIGHTS-1:0]            leds,
    output logic [1:0]                       winner,
    output logic                             round_over,
    output logic [$clog2(WIN_MAX+1)-1:0]     l_wins,
    output logic [$clog2(WIN_MAX+1)-1:0]     r_wins
);

    localparam int unsigned POS_W  = $clog2(NUM_LIGHTS);
    localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam int unsigned CENTRE = NUM_LIGHTS / 2;

    play_state_t         state, state_n;
    logic [POS_W-1:0]    pos, pos_n;
    logic [HOLD_W-1:0]   hold, hold_n;
    logic [NUM_LIGHTS-1:0] leds_n;
    logic [1:0]          winner_n;
    logic                round_over_n;
    logic                l_win_c, r_win_c;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_PLAY;
            pos        <= POS_W'(CENTRE);
            hold       <= '0;
            leds       <= NUM_LIGHTS'(1) << CENTRE;
            winner     <= WIN_NONE;
            round_over <= 1'b0;
        end else begin
            state      <= state_n;
            pos        <= pos_n;
            hold       <= hold_n;
            leds       <= leds_n;
            winner     <= winner_n;
            round_over <= round_over_n;
        end
    end

    // Next-state: simultaneous presses cancel; WON ignores all presses.
    always_comb begin
        state_n      = state;
        pos_n        = pos;
        hold_n       = hold;
        winner_n     = winner;
        round_over_n = 1'b0;
        l_win_c      = 1'b0;
        r_win_c      = 1'b0;
        unique case (state)
            S_PLAY: begin
                if (l_press && !r_press) begin
                    if (pos == POS_W'(NUM_LIGHTS - 1)) begin
                        state_n      = S_WON;
                        winner_n     = WIN_LEFT;
                        round_over_n = 1'b1;
                        hold_n       = '0;
                        l_win_c      = 1'b1;
                    end else begin
                        pos_n = pos + POS_W'(1);
                    end
                end else if (r_press && !l_press) begin
                    if (pos == '0) begin
                        state_n      = S_WON;
                        winner_n     = WIN_RIGHT;
                        round_over_n = 1'b1;
                        hold_n       = '0;
                        r_win_c      = 1'b1;
                    end else begin
                        pos_n = pos - POS_W'(1);
                    end
                end
            end
            S_WON: begin
                if (hold == HOLD_W'(HOLD_CYCLES - 1)) begin
                    state_n  = S_PLAY;
                    pos_n    = POS_W'(CENTRE);
                    winner_n = WIN_NONE;
                    hold_n   = '0;
                end else begin
                    hold_n = hold + HOLD_W'(1);
                end
            end
            default: state_n = S_PLAY;
        endcase
        leds_n = (state_n == S_PLAY) ? (NUM_LIGHTS'(1) << pos_n) : '0;
    end

    sat_counter #(.MAX(WIN_MAX)) u_l_wins (
        .clk   (clk),
        .reset (reset),
        .inc   (l_win_c),
        .count (l_wins)
    );

    sat_counter #(.MAX(WIN_MAX)) u_r_wins (
        .clk   (clk),
        .reset (reset),
        .inc   (r_win_c),
        .count (r_wins)
    );

endmodule

// File: tb/tb_tug_playfield.sv
// Directed bench for tug_playfield with hand-computed expected values.
module tb_tug_playfield;

    logic       clk = 1'b0;
    logic       reset;
    logic       l_press;
    logic       r_press;
    logic [8:0] leds;
    logic [1:0] winner;
    logic       round_over;
    logic [2:0] l_wins;
    logic [2:0] r_wins;

    int checks   = 0;
    int failures = 0;

    tug_playfield #(
        .NUM_LIGHTS  (9),
        .WIN_MAX     (7),
        .HOLD_CYCLES (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .l_press    (l_press),
        .r_press    (r_press),
        .leds       (leds),
        .winner     (winner),
        .round_over (round_over),
        .l_wins     (l_wins),
        .r_wins     (r_wins)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic l, input logic r);
        l_press = l;
        r_press = r;
        step();
        l_press = 1'b0;
        r_press = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset   = 1'b1;
        l_press = 1'b0;
        r_press = 1'b0;

        // 1. reset
        step();
        step();
        reset = 1'b0;
        chk("rst_leds", 32'(leds), 32'h010);
        chk("rst_winner", 32'(winner), 32'd0);
        chk("rst_round_over", 32'(round_over), 32'd0);
        chk("rst_l_wins", 32'(l_wins), 32'd0);
        chk("rst_r_wins", 32'(r_wins), 32'd0);

        // 2. three left steps with idle gaps
        press(1'b1, 1'b0);
        chk("step1_leds", 32'(leds), 32'h020);
        step();
        press(1'b1, 1'b0);
        chk("step2_leds", 32'(leds), 32'h040);
        step();
        press(1'b1, 1'b0);
        chk("step3_leds", 32'(leds), 32'h080);
        chk("step3_winner", 32'(winner), 32'd0);
        for (int i = 0; i < 3; i++) press(1'b0, 1'b1);
        chk("back_centre", 32'(leds), 32'h010);

        // 3. left win from centre
        for (int i = 0; i < 4; i++) press(1'b1, 1'b0);
        chk("l_edge_leds", 32'(leds), 32'h100);
        chk("l_edge_round_over", 32'(round_over), 32'd0);
        press(1'b1, 1'b0);
        chk("lwin_leds", 32'(leds), 32'h000);
        chk("lwin_winner", 32'(winner), 32'd1);
        chk("lwin_round_over", 32'(round_over), 32'd1);
        chk("lwin_l_wins", 32'(l_wins), 32'd1);
        step();
        chk("lwin_pulse_end", 32'(round_over), 32'd0);
        step();
        step();
        chk("hold_leds", 32'(leds), 32'h000);
        chk("hold_winner", 32'(winner), 32'd1);
        step();
        chk("restart_leds", 32'(leds), 32'h010);
        chk("restart_winner", 32'(winner), 32'd0);
        chk("restart_l_wins", 32'(l_wins), 32'd1);

        // 4. simultaneous presses cancel, then right win
        press(1'b1, 1'b1);
        chk("both_leds", 32'(leds), 32'h010);
        chk("both_l_wins", 32'(l_wins), 32'd1);
        chk("both_r_wins", 32'(r_wins), 32'd0);
        for (int i = 0; i < 4; i++) press(1'b0, 1'b1);
        chk("r_edge_leds", 32'(leds), 32'h001);
        press(1'b0, 1'b1);
        chk("rwin_leds", 32'(leds), 32'h000);
        chk("rwin_winner", 32'(winner), 32'd2);
        chk("rwin_round_over", 32'(round_over), 32'd1);
        chk("rwin_r_wins", 32'(r_wins), 32'd1);

        // 5. presses in WON, including the exit edge, are ignored
        press(1'b1, 1'b0);
        chk("won_l_ignored_leds", 32'(leds), 32'h000);
        chk("won_l_ignored_winner", 32'(winner), 32'd2);
        press(1'b0, 1'b1);
        press(1'b1, 1'b0);
        press(1'b1, 1'b0);
        chk("exit_leds", 32'(leds), 32'h010);
        chk("exit_winner", 32'(winner), 32'd0);
        chk("exit_l_wins", 32'(l_wins), 32'd1);
        chk("exit_r_wins", 32'(r_wins), 32'd1);
        step();
        chk("exit_hold_leds", 32'(leds), 32'h010);

        // 6. eight more left wins saturate at 7
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 5; j++) press(1'b1, 1'b0);
            chk("sat_l_wins", 32'(l_wins), (i + 2 > 7) ? 32'd7 : 32'(i + 2));
            if (i < 7) for (int j = 0; j < 4; j++) step();
        end
        chk("sat_winner", 32'(winner), 32'd1);
        step();

        // reset while in WON
        reset = 1'b1;
        step();
        chk("rst2_leds", 32'(leds), 32'h010);
        chk("rst2_winner", 32'(winner), 32'd0);
        chk("rst2_round_over", 32'(round_over), 32'd0);
        chk("rst2_l_wins", 32'(l_wins), 32'd0);
        chk("rst2_r_wins", 32'(r_wins), 32'd0);
        reset = 1'b0;
        press(1'b1, 1'b0);
        chk("post_rst_move", 32'(leds), 32'h020);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
